cpu_pipelined: RTL and testbench

//  5-stage pipelined CPU (IF/ID/EX/MEM/WB) for a MIPS-I integer subset; top level of the design.

---
 rtl/cpu_pipelined_pkg.sv | 44 ++++
 rtl/cpu_alu.sv | 23 ++
 rtl/cpu_control.sv | 45 ++++
 rtl/cpu_forwarding_unit.sv | 17 +
 rtl/cpu_hazard_unit.sv | 19 +
 rtl/cpu_mem.sv | 29 ++
 rtl/cpu_regfile.sv | 24 ++
 rtl/cpu_pipelined.sv | 174 +++++++++++++++++
 tb/tb_cpu_pipelined.sv | 191 +++++++++++++++++++
 9 files changed

// File: rtl/cpu_pipelined_pkg.sv
// Shared constants and types for the 5-stage MIPS-I subset pipeline.
package cpu_pipelined_pkg;

  localparam int unsigned XLEN = 32;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  typedef enum logic [1:0] {FwdNone, FwdExMem, FwdMemWb} fwd_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;   // also selects load data at writeback
    logic    mem_write;
    logic    branch;
    logic    alu_src;    // 1: second ALU operand is the sign-extended immediate
    alu_op_e alu_op;
  } ctrl_t;

  // All-zero control word: a pipeline bubble
  localparam ctrl_t CtrlNop = '0;

  // Operand source for EX; the younger producer (EX/MEM) wins over MEM/WB.
  function automatic fwd_sel_e fwd_select(logic [4:0] src, logic em_we, logic [4:0] em_dst,
                                          logic mw_we, logic [4:0] mw_dst);
    if (em_we && em_dst != 5'd0 && em_dst == src) return FwdExMem;
    if (mw_we && mw_dst != 5'd0 && mw_dst == src) return FwdMemWb;
    return FwdNone;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Integer ALU; arithmetic wraps, slt is signed.
module cpu_alu
  import cpu_pipelined_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] y_o
);
  // Operation select
  always_comb begin
    y_o = '0;
    case (op_i)
      AluAdd:  y_o = a_i + b_i;
      AluSub:  y_o = a_i - b_i;
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluSlt:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      default: y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Main decoder: opcode/funct to control word. Anything unrecognised is a bubble.
module cpu_control
  import cpu_pipelined_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       reg_dst_o
);
  // Decode
  always_comb begin
    ctrl_o    = CtrlNop;
    reg_dst_o = 1'b0;
    case (op_i)
      OpRtype: begin
        reg_dst_o        = 1'b1;
        ctrl_o.reg_write = 1'b1;
        case (funct_i)
          FnAdd:   ctrl_o.alu_op = AluAdd;
          FnSub:   ctrl_o.alu_op = AluSub;
          FnAnd:   ctrl_o.alu_op = AluAnd;
          FnOr:    ctrl_o.alu_op = AluOr;
          FnSlt:   ctrl_o.alu_op = AluSlt;
          default: ctrl_o.reg_write = 1'b0;  // includes the all-zero NOP
        endcase
      end
      OpAddi: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      OpLw: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      OpSw: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      OpBeq:   ctrl_o.branch = 1'b1;
      default: ctrl_o = CtrlNop;
    endcase
  end

endmodule

// File: rtl/cpu_forwarding_unit.sv
// Selects the EX operand sources from the EX/MEM and MEM/WB producers.
module cpu_forwarding_unit
  import cpu_pipelined_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       ex_mem_we_i,
  input  logic [4:0] ex_mem_dst_i,
  input  logic       mem_wb_we_i,
  input  logic [4:0] mem_wb_dst_i,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);
  assign fwd_a_o = fwd_select(rs_i, ex_mem_we_i, ex_mem_dst_i, mem_wb_we_i, mem_wb_dst_i);
  assign fwd_b_o = fwd_select(rt_i, ex_mem_we_i, ex_mem_dst_i, mem_wb_we_i, mem_wb_dst_i);

endmodule

// File: rtl/cpu_hazard_unit.sv
// Load-use detection: lw in EX feeding the instruction in ID.
module cpu_hazard_unit
  import cpu_pipelined_pkg::*;
(
  input  logic       id_ex_mem_read_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic [5:0] if_id_op_i,
  input  logic [4:0] if_id_rs_i,
  input  logic [4:0] if_id_rt_i,
  output logic       stall_o
);
  logic uses_rt;

  // rt is a source only for R-type, sw (store data) and beq
  assign uses_rt = if_id_op_i inside {OpRtype, OpSw, OpBeq};
  assign stall_o = id_ex_mem_read_i &&
                   (id_ex_rt_i == if_id_rs_i || (uses_rt && id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/cpu_mem.sv
// Word-addressed memory with combinational read and rising-edge write.
module cpu_mem
  import cpu_pipelined_pkg::*;
#(
  parameter int unsigned Depth = 32
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);
  localparam int unsigned AW = $clog2(Depth);

  logic [XLEN-1:0] data [Depth];
  logic [AW-1:0]   idx;
  logic            unused_addr;

  // Byte address to word index; higher bits are dropped so addresses wrap
  assign idx         = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[XLEN-1:AW+2], addr_i[1:0]};
  assign rdata_o     = data[idx];

  // Contents may be preloaded hierarchically, so this stays a plain always
  always @(posedge clk_i) begin
    if (we_i) data[idx] <= wdata_i;
  end

endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational reads, one falling-edge write.
module cpu_regfile
  import cpu_pipelined_pkg::*;
(
  input  logic            clk_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);
  logic [XLEN-1:0] data [32];

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : data[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : data[raddr2_i];

  // Falling-edge write lets ID see the WB value in the same cycle; $0 is never written
  always @(negedge clk_i) begin
    if (we_i && waddr_i != 5'd0) data[waddr_i] <= wdata_i;
  end

endmodule

// File: rtl/cpu_pipelined.sv
// 5-stage pipelined MIPS-I subset CPU with forwarding, load-use stall and EX-resolved beq.
module cpu_pipelined
  import cpu_pipelined_pkg::*;
#(
  parameter int unsigned INSTR_MEM_SIZE = 64,
  parameter int unsigned DATA_MEM_SIZE  = 32
) (
  input logic clock,
  input logic reset
);
  logic [XLEN-1:0] pc_q, pc_plus4, if_instr;
  logic [XLEN-1:0] if_id_instr_q, if_id_pc4_q;
  logic [5:0]      id_op, id_funct;
  logic [4:0]      id_rs, id_rt, id_rd, id_dst;
  logic [XLEN-1:0] id_imm, id_rdata1, id_rdata2;
  ctrl_t           id_ctrl;
  logic            id_reg_dst, stall;
  ctrl_t           id_ex_ctrl_q;
  logic [XLEN-1:0] id_ex_pc4_q, id_ex_rdata1_q, id_ex_rdata2_q, id_ex_imm_q;
  logic [4:0]      id_ex_rs_q, id_ex_rt_q, id_ex_dst_q;
  fwd_sel_e        fwd_a, fwd_b;
  logic [XLEN-1:0] ex_a, ex_b, ex_alu_b, ex_alu_y, ex_target;
  logic            ex_taken;
  logic            ex_mem_reg_write_q, ex_mem_mem_read_q, ex_mem_mem_write_q;
  logic [XLEN-1:0] ex_mem_alu_q, ex_mem_wdata_q, mem_rdata;
  logic [4:0]      ex_mem_dst_q;
  logic            mem_wb_reg_write_q, mem_wb_mem_read_q;
  logic [XLEN-1:0] mem_wb_alu_q, mem_wb_rdata_q, wb_data;
  logic [4:0]      mem_wb_dst_q;

  // ---------------- IF ----------------
  assign pc_plus4 = pc_q + 32'd4;

  cpu_mem #(.Depth(INSTR_MEM_SIZE)) InstructionMemory_0 (
    .clk_i(clock), .we_i(1'b0), .addr_i(pc_q), .wdata_i('0), .rdata_o(if_instr)
  );

  // PC: taken branch beats a stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        pc_q <= '0;
    else if (ex_taken) pc_q <= ex_target;
    else if (!stall)   pc_q <= pc_plus4;
  end

  // IF/ID: flush on taken branch, hold on load-use
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || ex_taken) begin
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
    end else if (!stall) begin
      if_id_instr_q <= if_instr;
      if_id_pc4_q   <= pc_plus4;
    end
  end

  // ---------------- ID ----------------
  assign id_op    = if_id_instr_q[31:26];
  assign id_rs    = if_id_instr_q[25:21];
  assign id_rt    = if_id_instr_q[20:16];
  assign id_rd    = if_id_instr_q[15:11];
  assign id_funct = if_id_instr_q[5:0];
  assign id_imm   = {{16{if_id_instr_q[15]}}, if_id_instr_q[15:0]};
  assign id_dst   = id_reg_dst ? id_rd : id_rt;

  cpu_control u_control (
    .op_i(id_op), .funct_i(id_funct), .ctrl_o(id_ctrl), .reg_dst_o(id_reg_dst)
  );

  cpu_regfile Registers_0 (
    .clk_i(clock), .raddr1_i(id_rs), .raddr2_i(id_rt), .rdata1_o(id_rdata1),
    .rdata2_o(id_rdata2), .we_i(mem_wb_reg_write_q), .waddr_i(mem_wb_dst_q), .wdata_i(wb_data)
  );

  cpu_hazard_unit u_hazard (
    .id_ex_mem_read_i(id_ex_ctrl_q.mem_read), .id_ex_rt_i(id_ex_rt_q), .if_id_op_i(id_op),
    .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .stall_o(stall)
  );

  // ID/EX: bubble on taken branch or load-use stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_ctrl_q   <= CtrlNop;
      id_ex_pc4_q    <= '0;
      id_ex_rdata1_q <= '0;
      id_ex_rdata2_q <= '0;
      id_ex_imm_q    <= '0;
      id_ex_rs_q     <= '0;
      id_ex_rt_q     <= '0;
      id_ex_dst_q    <= '0;
    end else begin
      id_ex_ctrl_q   <= (ex_taken || stall) ? CtrlNop : id_ctrl;
      id_ex_pc4_q    <= if_id_pc4_q;
      id_ex_rdata1_q <= id_rdata1;
      id_ex_rdata2_q <= id_rdata2;
      id_ex_imm_q    <= id_imm;
      id_ex_rs_q     <= id_rs;
      id_ex_rt_q     <= id_rt;
      id_ex_dst_q    <= id_dst;
    end
  end

  // ---------------- EX ----------------
  cpu_forwarding_unit u_forwarding (
    .rs_i(id_ex_rs_q), .rt_i(id_ex_rt_q), .ex_mem_we_i(ex_mem_reg_write_q),
    .ex_mem_dst_i(ex_mem_dst_q), .mem_wb_we_i(mem_wb_reg_write_q), .mem_wb_dst_i(mem_wb_dst_q),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
  );

  // Operand muxes; operand b doubles as sw store data
  always_comb begin
    case (fwd_a)
      FwdExMem: ex_a = ex_mem_alu_q;
      FwdMemWb: ex_a = wb_data;
      default:  ex_a = id_ex_rdata1_q;
    endcase
    case (fwd_b)
      FwdExMem: ex_b = ex_mem_alu_q;
      FwdMemWb: ex_b = wb_data;
      default:  ex_b = id_ex_rdata2_q;
    endcase
  end

  assign ex_alu_b  = id_ex_ctrl_q.alu_src ? id_ex_imm_q : ex_b;
  assign ex_taken  = id_ex_ctrl_q.branch && (ex_a == ex_b);
  assign ex_target = id_ex_pc4_q + {id_ex_imm_q[XLEN-3:0], 2'b00};

  cpu_alu u_alu (.a_i(ex_a), .b_i(ex_alu_b), .op_i(id_ex_ctrl_q.alu_op), .y_o(ex_alu_y));

  // EX/MEM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_mem_reg_write_q <= 1'b0;
      ex_mem_mem_read_q  <= 1'b0;
      ex_mem_mem_write_q <= 1'b0;
      ex_mem_alu_q       <= '0;
      ex_mem_wdata_q     <= '0;
      ex_mem_dst_q       <= '0;
    end else begin
      ex_mem_reg_write_q <= id_ex_ctrl_q.reg_write;
      ex_mem_mem_read_q  <= id_ex_ctrl_q.mem_read;
      ex_mem_mem_write_q <= id_ex_ctrl_q.mem_write;
      ex_mem_alu_q       <= ex_alu_y;
      ex_mem_wdata_q     <= ex_b;
      ex_mem_dst_q       <= id_ex_dst_q;
    end
  end

  // ---------------- MEM ----------------
  cpu_mem #(.Depth(DATA_MEM_SIZE)) DataMemory_0 (
    .clk_i(clock), .we_i(ex_mem_mem_write_q), .addr_i(ex_mem_alu_q),
    .wdata_i(ex_mem_wdata_q), .rdata_o(mem_rdata)
  );

  // MEM/WB
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wb_reg_write_q <= 1'b0;
      mem_wb_mem_read_q  <= 1'b0;
      mem_wb_alu_q       <= '0;
      mem_wb_rdata_q     <= '0;
      mem_wb_dst_q       <= '0;
    end else begin
      mem_wb_reg_write_q <= ex_mem_reg_write_q;
      mem_wb_mem_read_q  <= ex_mem_mem_read_q;
      mem_wb_alu_q       <= ex_mem_alu_q;
      mem_wb_rdata_q     <= mem_rdata;
      mem_wb_dst_q       <= ex_mem_dst_q;
    end
  end

  // ---------------- WB ----------------
  assign wb_data = mem_wb_mem_read_q ? mem_wb_rdata_q : mem_wb_alu_q;

endmodule

// File: tb/tb_cpu_pipelined.sv
// Scoreboard bench: expected writebacks/stores (value and cycle) are queued per run and
// checked by a monitor as they leave the pipeline; final architectural state is checked too.
module tb_cpu_pipelined;

  logic clock;
  logic reset;

  cpu_pipelined #(.INSTR_MEM_SIZE(64), .DATA_MEM_SIZE(32)) dut (.clock(clock), .reset(reset));

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {int dst; logic [31:0] val; int cyc;} wb_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} st_t;

  wb_t wb_q[$];
  st_t st_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc;

  // Hand-computed writebacks (regs preset to i): dest, value, rising edge it enters MEM/WB
  int          wb_dst [12] = '{2, 4, 11, 5, 8, 9, 13, 14, 15, 16, 17, 18};
  logic [31:0] wb_val [12] = '{32'd4, 32'd3, 32'd4, 32'd4, 32'd8, 32'd16, 32'd31,
                               32'd1, 32'hFFFF_FFFD, 32'd1, 32'd5, 32'd11};
  int          wb_cyc [12] = '{4, 5, 6, 8, 9, 11, 12, 19, 20, 21, 22, 23};
  // Stores: byte address, data, edge the sw enters EX/MEM
  logic [31:0] st_addr [2] = '{32'd48, 32'd4};
  logic [31:0] st_data [2] = '{32'd31, 32'd11};
  int          st_cyc  [2] = '{12, 24};

  logic [31:0] exp_reg [32];
  logic [31:0] exp_dm  [32];

  // Rising edges since reset release
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [31:0] r_type(int rs, int rt, int rd, logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    logic [4:0] s, t;
    s = rs[4:0]; t = rt[4:0];
    return {op, s, t, imm};
  endfunction

  task automatic push_expect(input int n_wb, input int n_st);
    wb_t w;
    st_t s;
    for (int i = 0; i < n_wb; i++) begin
      w.dst = wb_dst[i]; w.val = wb_val[i]; w.cyc = wb_cyc[i];
      wb_q.push_back(w);
    end
    for (int i = 0; i < n_st; i++) begin
      s.addr = st_addr[i]; s.data = st_data[i]; s.cyc = st_cyc[i];
      st_q.push_back(s);
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_wb_left"}, wb_q.size(), 0);
    chk({tag, "_st_left"}, st_q.size(), 0);
    wb_q.delete();
    st_q.delete();
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_reg%0d", tag, i), dut.Registers_0.data[i], exp_reg[i]);
      chk($sformatf("%s_dm%0d", tag, i), dut.DataMemory_0.data[i], exp_dm[i]);
    end
  endtask

  // Monitor: compare whatever leaves the pipeline against the scoreboard
  always @(negedge clock) begin
    wb_t w;
    st_t s;
    if (dut.mem_wb_reg_write_q && dut.mem_wb_dst_q != 5'd0) begin
      if (wb_q.size() == 0) begin
        n_checks++;
        $display("FAIL wb_unexpected: got $%0d=%0h at edge %0d, required no writeback",
                 dut.mem_wb_dst_q, dut.wb_data, cyc);
      end else begin
        w = wb_q.pop_front();
        chk($sformatf("wb%0d_dst", w.dst), 32'(dut.mem_wb_dst_q), w.dst);
        chk($sformatf("wb%0d_val", w.dst), dut.wb_data, w.val);
        chk($sformatf("wb%0d_cycle", w.dst), cyc, w.cyc);
      end
    end
    if (dut.ex_mem_mem_write_q) begin
      if (st_q.size() == 0) begin
        n_checks++;
        $display("FAIL st_unexpected: got store %0h to %0h at edge %0d, required none",
                 dut.ex_mem_wdata_q, dut.ex_mem_alu_q, cyc);
      end else begin
        s = st_q.pop_front();
        chk("st_addr", dut.ex_mem_alu_q, s.addr);
        chk("st_data", dut.ex_mem_wdata_q, s.data);
        chk("st_cycle", cyc, s.cyc);
      end
    end
  end

  initial begin
    logic [31:0] prog [21];
    reset = 1'b0;
    prog[0]  = r_type(1, 3, 2, 6'h20);             // add  $2,$1,$3
    prog[1]  = r_type(2, 1, 4, 6'h22);             // sub  $4,$2,$1
    prog[2]  = r_type(1, 3, 11, 6'h20);            // add  $11,$1,$3
    prog[3]  = 32'h0000_0000;                      // nop
    prog[4]  = r_type(11, 0, 5, 6'h25);            // or   $5,$11,$0
    prog[5]  = i_type(6'h23, 0, 8, 16'd32);        // lw   $8,32($0)
    prog[6]  = r_type(8, 8, 9, 6'h20);             // add  $9,$8,$8
    prog[7]  = i_type(6'h08, 0, 13, 16'd31);       // addi $13,$0,31
    prog[8]  = i_type(6'h2B, 0, 13, 16'd48);       // sw   $13,48($0)
    prog[9]  = i_type(6'h04, 1, 1, 16'd2);         // beq  $1,$1,+2 (taken)
    prog[10] = i_type(6'h08, 0, 20, 16'd99);       // addi $20 (skipped)
    prog[11] = i_type(6'h08, 0, 21, 16'd99);       // addi $21 (skipped)
    prog[12] = i_type(6'h04, 1, 2, 16'd2);         // beq  $1,$2,+2 (not taken)
    prog[13] = r_type(1, 1, 0, 6'h20);             // add  $0,$1,$1
    prog[14] = r_type(4, 2, 14, 6'h2A);            // slt  $14,$4,$2
    prog[15] = r_type(1, 2, 15, 6'h22);            // sub  $15,$1,$2
    prog[16] = r_type(15, 1, 16, 6'h2A);           // slt  $16,$15,$1 (signed)
    prog[17] = r_type(15, 7, 17, 6'h24);           // and  $17,$15,$7
    prog[18] = i_type(6'h23, 0, 18, 16'd44);       // lw   $18,44($0)
    prog[19] = i_type(6'h2B, 0, 18, 16'd4);        // sw   $18,4($0) (load-use on rt)
    prog[20] = i_type(6'h04, 0, 0, 16'hFFFF);      // beq  $0,$0,-1 (halt loop)
    for (int i = 0; i < 64; i++) dut.InstructionMemory_0.data[i] = (i < 21) ? prog[i] : '0;
    for (int i = 0; i < 32; i++) begin
      dut.Registers_0.data[i]  = i;
      dut.DataMemory_0.data[i] = i;
      exp_reg[i] = i;
      exp_dm[i]  = i;
    end
    exp_reg[2] = 4;  exp_reg[4] = 3;  exp_reg[5] = 4;  exp_reg[9] = 16; exp_reg[11] = 4;
    exp_reg[13] = 31; exp_reg[14] = 1; exp_reg[15] = 32'hFFFF_FFFD; exp_reg[16] = 1;
    exp_reg[17] = 5; exp_reg[18] = 11;
    exp_dm[12] = 31; exp_dm[1] = 11;

    // Run 1: full program from reset
    push_expect(12, 2);
    #5 reset = 1'b1;
    repeat (40) @(negedge clock);
    check_drained("run1");
    check_state("run1");

    // Reset while looping: squash at once, keep architectural state
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", dut.pc_q, 0);
    chk("rst_memwb_we", 32'(dut.mem_wb_reg_write_q), 0);
    chk("rst_exmem_we", 32'(dut.ex_mem_mem_write_q), 0);
    check_state("rst");

    // Run 2: stop mid-program after edge 7; only the first three writebacks may appear
    push_expect(3, 0);
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_pc", dut.pc_q, 0);
    chk("midrst_ifid", dut.if_id_instr_q, 0);
    chk("midrst_idex_we", 32'(dut.id_ex_ctrl_q.reg_write), 0);
    check_drained("run2");

    // Run 3: restart from PC 0 with retained state
    push_expect(12, 2);
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (40) @(negedge clock);
    check_drained("run3");
    check_state("run3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
